// File: rtl/multi_ram_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multi_ram_bus_ctrl
// Purpose  : Bridge from the MicroBlaze register/GPIO port to a bank of
//            N_RAM dual-port RAMs. Each rising edge of Write_in or Read_in
//            becomes one addressed transaction: a registered one-hot chip
//            select, an address and (for writes) data with a one-cycle wr.
//            A read waits RD_LAT cycles, captures the selected RAM's read
//            bus into Data_rd and pulses rd_valid.
// Ports    : clk, reset (sync, active-high)
//            RAM_sel / Addr_in / Data_in   - request target, address, data
//            Write_in / Read_in            - request strobes (edge detected)
//            rd_data_bus                   - RAM i at [i*DATA_W +: DATA_W]
//            Ram_Addr / ram_cs / Data / wr - RAM-side transaction outputs
//            Data_rd / rd_valid / busy     - read return path and status
//            sel_err / collision           - one-cycle error pulses
// Revision : 1.0 - initial release
// ============================================================================
module multi_ram_bus_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13,
  parameter int SEL_W  = 4,
  parameter int N_RAM  = 16,
  parameter int RD_LAT = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SEL_W-1:0]        RAM_sel,
  input  logic [DATA_W-1:0]       Data_in,
  input  logic [ADDR_W-1:0]       Addr_in,
  input  logic                    Write_in,
  input  logic                    Read_in,
  input  logic [N_RAM*DATA_W-1:0] rd_data_bus,
  output logic [ADDR_W-1:0]       Ram_Addr,
  output logic [N_RAM-1:0]        ram_cs,
  output logic [DATA_W-1:0]       Data,
  output logic                    wr,
  output logic [DATA_W-1:0]       Data_rd,
  output logic                    rd_valid,
  output logic                    busy,
  output logic                    sel_err,
  output logic                    collision
);

  localparam logic [0:0]       IDLE     = 1'b0;
  localparam logic [0:0]       RD_WAIT  = 1'b1;
  localparam logic [3:0]       CNT_INIT = 4'(RD_LAT - 1);
  localparam logic [SEL_W:0]   N_RAM_W  = (SEL_W + 1)'(N_RAM);

  logic [0:0]        state_q, state_d;
  logic              w_q, w_d;
  logic              r_q, r_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [SEL_W-1:0]  sel_lat_q, sel_lat_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [N_RAM-1:0]  ram_cs_q, ram_cs_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] data_rd_q, data_rd_d;
  logic              rd_valid_q, rd_valid_d;
  logic              sel_err_q, sel_err_d;
  logic              collision_q, collision_d;

  logic              wr_req, rd_req, sel_ok, busy_o;
  logic [N_RAM-1:0]  cs_onehot;
  logic [DATA_W-1:0] rd_slice;

  // Edge detect: w_q/r_q come out of reset high so a strobe that is already
  // asserted at reset release is not mistaken for a new request.
  assign wr_req = Write_in & ~w_q;
  assign rd_req = Read_in  & ~r_q;
  assign sel_ok = ({1'b0, RAM_sel} < N_RAM_W);

  always_comb begin
    cs_onehot = '0;
    for (int i = 0; i < N_RAM; i++) begin
      cs_onehot[i] = (RAM_sel == SEL_W'(i));
    end
  end

  // Read mux uses the select latched at request time, not the live RAM_sel.
  always_comb begin
    rd_slice = '0;
    for (int i = 0; i < N_RAM; i++) begin
      if (sel_lat_q == SEL_W'(i)) begin
        rd_slice = rd_data_bus[i*DATA_W +: DATA_W];
      end
    end
  end

  // ---------------------------------------------------------------- FSM ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        // A simultaneous write takes priority, so a read only starts alone.
        if (rd_req && !wr_req && sel_ok) begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == RD_WAIT);
  end

  // ----------------------------------------------------------- datapath ----
  always_comb begin
    w_d         = Write_in;
    r_d         = Read_in;
    cnt_d       = cnt_q;
    sel_lat_d   = sel_lat_q;
    ram_addr_d  = ram_addr_q;
    ram_cs_d    = ram_cs_q;
    data_d      = '0;
    wr_d        = 1'b0;
    data_rd_d   = data_rd_q;
    rd_valid_d  = 1'b0;
    sel_err_d   = 1'b0;
    collision_d = 1'b0;

    case (state_q)
      IDLE: begin
        collision_d = wr_req & rd_req;
        if (wr_req || rd_req) begin
          if (!sel_ok) begin
            // Illegal target: flag it and leave the RAM-side outputs alone.
            sel_err_d = 1'b1;
          end else if (wr_req) begin
            wr_d       = 1'b1;
            data_d     = Data_in;
            ram_addr_d = Addr_in;
            ram_cs_d   = cs_onehot;
          end else begin
            ram_addr_d = Addr_in;
            ram_cs_d   = cs_onehot;
            sel_lat_d  = RAM_sel;
            cnt_d      = CNT_INIT;
          end
        end
      end
      RD_WAIT: begin
        // Requests during an outstanding read are dropped, not queued.
        collision_d = wr_req | rd_req;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          data_rd_d  = rd_slice;
          rd_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_q         <= 1'b1;
      r_q         <= 1'b1;
      cnt_q       <= '0;
      sel_lat_q   <= '0;
      ram_addr_q  <= '0;
      ram_cs_q    <= '0;
      data_q      <= '0;
      wr_q        <= 1'b0;
      data_rd_q   <= '0;
      rd_valid_q  <= 1'b0;
      sel_err_q   <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      w_q         <= w_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      sel_lat_q   <= sel_lat_d;
      ram_addr_q  <= ram_addr_d;
      ram_cs_q    <= ram_cs_d;
      data_q      <= data_d;
      wr_q        <= wr_d;
      data_rd_q   <= data_rd_d;
      rd_valid_q  <= rd_valid_d;
      sel_err_q   <= sel_err_d;
      collision_q <= collision_d;
    end
  end

  assign Ram_Addr  = ram_addr_q;
  assign ram_cs    = ram_cs_q;
  assign Data      = data_q;
  assign wr        = wr_q;
  assign Data_rd   = data_rd_q;
  assign rd_valid  = rd_valid_q;
  assign busy      = busy_o;
  assign sel_err   = sel_err_q;
  assign collision = collision_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_ram_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_ram_bus_ctrl
// Purpose  : Directed scoreboard bench for multi_ram_bus_ctrl with
//            N_RAM=12, RD_LAT=2. Stimulus pushes the expected output
//            snapshot of every wr/rd_valid/sel_err/collision cycle; a
//            negedge monitor pops and compares whenever one of them is high.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_ram_bus_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 13;
  localparam int SEL_W  = 4;
  localparam int N_RAM  = 12;
  localparam int RD_LAT = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [SEL_W-1:0]        RAM_sel;
  logic [DATA_W-1:0]       Data_in;
  logic [ADDR_W-1:0]       Addr_in;
  logic                    Write_in;
  logic                    Read_in;
  logic [N_RAM*DATA_W-1:0] rd_data_bus;
  logic [ADDR_W-1:0]       Ram_Addr;
  logic [N_RAM-1:0]        ram_cs;
  logic [DATA_W-1:0]       Data;
  logic                    wr;
  logic [DATA_W-1:0]       Data_rd;
  logic                    rd_valid;
  logic                    busy;
  logic                    sel_err;
  logic                    collision;

  multi_ram_bus_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEL_W(SEL_W),
    .N_RAM(N_RAM), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .reset(reset), .RAM_sel(RAM_sel), .Data_in(Data_in),
    .Addr_in(Addr_in), .Write_in(Write_in), .Read_in(Read_in),
    .rd_data_bus(rd_data_bus), .Ram_Addr(Ram_Addr), .ram_cs(ram_cs),
    .Data(Data), .wr(wr), .Data_rd(Data_rd), .rd_valid(rd_valid),
    .busy(busy), .sel_err(sel_err), .collision(collision)
  );

  always #5 clk = ~clk;

  // Snapshot: {wr, rd_valid, sel_err, collision, busy, cs, addr, data, data_rd}
  typedef logic [5+N_RAM+ADDR_W+2*DATA_W-1:0] ev_t;
  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  function automatic ev_t mk(input logic w, input logic rv, input logic se,
                             input logic co, input logic bz,
                             input logic [N_RAM-1:0] cs,
                             input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d,
                             input logic [DATA_W-1:0] drd);
    return {w, rv, se, co, bz, cs, a, d, drd};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every output pulse must match the oldest expected snapshot.
  always @(negedge clk) begin
    if (wr || rd_valid || sel_err || collision) begin
      ev_t act;
      act = mk(wr, rd_valid, sel_err, collision, busy, ram_cs, Ram_Addr, Data, Data_rd);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: got %h expected none", act);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (act !== e) begin
          failures++;
          $display("FAIL event: got %h expected %h", act, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  int busy_cnt;

  initial begin
    reset = 1'b1; RAM_sel = '0; Data_in = '0; Addr_in = '0;
    Write_in = 1'b1; Read_in = 1'b0;
    for (int i = 0; i < N_RAM; i++) rd_data_bus[i*DATA_W +: DATA_W] = 32'hA0A0_0000 + i;
    rd_data_bus[3*DATA_W +: DATA_W] = 32'h1234_5678;
    rd_data_bus[7*DATA_W +: DATA_W] = 32'hCAFE_0007;
    tick(3);
    check("reset_outputs", {Ram_Addr, ram_cs, Data, wr, Data_rd, rd_valid, busy, sel_err, collision}, '0);

    // Release reset with Write_in already high: no write may appear.
    reset = 1'b0;
    tick(4);
    check("release_outputs", {Ram_Addr, ram_cs, Data, wr, Data_rd, rd_valid, busy, sel_err, collision}, '0);
    Write_in = 1'b0;
    tick(2);

    // Single write held high for 4 cycles -> exactly one wr.
    RAM_sel = 4'd5; Addr_in = 13'h1A3; Data_in = 32'hDEAD_BEEF;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 12'h020, 13'h1A3, 32'hDEAD_BEEF, 32'h0));
    Write_in = 1'b1;
    tick(4);
    Write_in = 1'b0;
    tick(2);
    check("data_zero_after_wr", Data, 0);
    check("cs_hold_after_wr", {ram_cs, Ram_Addr}, {12'h020, 13'h1A3});

    // Read RAM3: busy for exactly RD_LAT cycles, then rd_valid.
    RAM_sel = 4'd3; Addr_in = 13'h0AB;
    exp_q.push_back(mk(0, 1, 0, 0, 0, 12'h008, 13'h0AB, 32'h0, 32'h1234_5678));
    Read_in = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check("read_busy_cycles", busy_cnt, RD_LAT);
    Read_in = 1'b0;
    tick(2);

    // Simultaneous write and read: write wins, collision, never busy.
    RAM_sel = 4'd1; Addr_in = 13'h055; Data_in = 32'h0BAD_F00D;
    exp_q.push_back(mk(1, 0, 0, 1, 0, 12'h002, 13'h055, 32'h0BAD_F00D, 32'h1234_5678));
    Write_in = 1'b1; Read_in = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check("collision_no_busy", busy_cnt, 0);
    Write_in = 1'b0; Read_in = 1'b0;
    tick(2);

    // Write edge during RD_WAIT: dropped with collision, read still completes.
    RAM_sel = 4'd7; Addr_in = 13'h100;
    exp_q.push_back(mk(0, 0, 0, 1, 1, 12'h080, 13'h100, 32'h0, 32'h1234_5678));
    exp_q.push_back(mk(0, 1, 0, 0, 0, 12'h080, 13'h100, 32'h0, 32'hCAFE_0007));
    Read_in = 1'b1;
    tick(1);
    RAM_sel = 4'd2; Addr_in = 13'h0EE; Data_in = 32'h5555_AAAA;
    Write_in = 1'b1;
    tick(4);
    Write_in = 1'b0; Read_in = 1'b0;
    tick(2);

    // Illegal select (13 >= 12): sel_err only, cs/addr untouched.
    RAM_sel = 4'd13; Addr_in = 13'h1FF; Data_in = 32'h1111_2222;
    exp_q.push_back(mk(0, 0, 1, 0, 0, 12'h080, 13'h100, 32'h0, 32'hCAFE_0007));
    Write_in = 1'b1;
    tick(3);
    Write_in = 1'b0;
    tick(2);
    check("sel_err_cs_hold", {ram_cs, Ram_Addr, busy}, {12'h080, 13'h100, 1'b0});

    // Reset in cycle k+1 of a read: outputs clear, no rd_valid afterwards.
    RAM_sel = 4'd4; Addr_in = 13'h044;
    Read_in = 1'b1;
    tick(1);
    check("midread_busy", busy, 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("midread_reset_outputs", {Ram_Addr, ram_cs, Data, wr, Data_rd, rd_valid, busy, sel_err, collision}, '0);
    tick(6);
    Read_in = 1'b0;
    tick(2);
    check("no_busy_after_reset", busy, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_ram_bus_ctrl.md
# multi_ram_bus_ctrl

Parametrised bridge between the MicroBlaze register port and a bank of N_RAM dual-port RAMs or register files. It detects rising edges on the write and read strobes and turns each into one addressed transaction. Each transaction drives a registered one-hot chip select, address and data. Reads are supported: after a fixed RAM latency the selected RAM's read bus is captured and returned with a valid pulse. The block sits between the processor GPIO/register interface and the DPRAM array.

## Interface
- DATA_W, 32, data width of the write path and of each RAM read bus
- ADDR_W, 13, RAM address width
- SEL_W, 4, width of RAM_sel
- N_RAM, 16, number of chip selects; legal range 1..2^SEL_W
- RD_LAT, 2, RAM read latency in clk cycles; legal range 1..15
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- RAM_sel  in  SEL_W  target RAM index
- Data_in  in  DATA_W  write data (signed)
- Addr_in  in  ADDR_W  RAM address
- Write_in  in  1  write strobe; its rising edge requests a write
- Read_in  in  1  read strobe; its rising edge requests a read
- rd_data_bus  in  N_RAM*DATA_W  concatenated RAM read ports; RAM i occupies bits [i*DATA_W +: DATA_W]
- Ram_Addr  out  ADDR_W  registered address of the current or last transaction
- ram_cs  out  N_RAM  registered one-hot chip select
- Data  out  DATA_W  write data; forced to 0 whenever wr=0
- wr  out  1  one-cycle write enable
- Data_rd  out  DATA_W  captured read data, held until the next read completes
- rd_valid  out  1  one-cycle pulse when Data_rd updates
- busy  out  1  high while a read is outstanding
- sel_err  out  1  one-cycle pulse: request had RAM_sel >= N_RAM
- collision  out  1  one-cycle pulse: a request was dropped

## Operation
- Edge detect:
  - Registers w_q and r_q hold the previous-cycle Write_in and Read_in.
  - wr_req = Write_in & ~w_q; rd_req = Read_in & ~r_q.
  - w_q and r_q reset to 1, so a strobe already high when reset is released produces no request.
- FSM states are IDLE and RD_WAIT. The state resets to IDLE.
- IDLE with wr_req and a legal sel:
  - Next cycle: wr=1, Data=Data_in, Ram_Addr=Addr_in, ram_cs=1<<RAM_sel.
  - wr then returns to 0 and Data to 0.
  - ram_cs and Ram_Addr hold their values until the next transaction.
- IDLE with rd_req and a legal sel:
  - Load Ram_Addr and ram_cs.
  - Go to RD_WAIT with busy=1 and cnt=RD_LAT-1.
  - The request's sel is latched for the read mux.
- RD_WAIT:
  - If cnt != 0, decrement cnt.
  - If cnt == 0: Data_rd <= rd_data_bus slice[latched sel], rd_valid=1, busy=0, go to IDLE.
- wr_req and rd_req in the same IDLE cycle: the write wins, the read is dropped, and collision pulses.
- Any wr_req or rd_req while in RD_WAIT: dropped, collision pulses, and the read completes normally.
- Illegal sel (RAM_sel >= N_RAM):
  - sel_err pulses.
  - No wr is issued and no read starts.
  - ram_cs, Ram_Addr and the FSM state are unchanged.
- Reset, including mid-read:
  - FSM returns to IDLE and cnt=0.
  - All outputs go to 0: Ram_Addr, ram_cs, Data, wr, Data_rd, rd_valid, busy, sel_err, collision.
  - No rd_valid is issued for the aborted read.

## Timing
- Write latency is 1 cycle:
  - The request is sampled at edge k, and wr is high during the cycle after edge k.
  - Strobe width does not matter; holding Write_in high gives exactly one wr.
- Back-to-back writes need Write_in low for at least 1 cycle. The maximum rate is one write every 2 cycles.
- Read timing, with rd_req sampled at edge k:
  - ram_cs and Ram_Addr are valid after edge k.
  - rd_data_bus is sampled at edge k+RD_LAT.
  - rd_valid is high and busy is low in the cycle after edge k+RD_LAT.
  - busy is high during cycles k+1 .. k+RD_LAT.
- The earliest new request after a read is accepted at edge k+RD_LAT+1.
- sel_err and collision are registered and assert in the cycle after the offending edge.

## Test plan
- Reset release with Write_in=1 held -> wr never asserts; all outputs 0.
- Write: sel=5, Addr=0x1A3, Data=0xDEADBEEF; Write_in 0→1 held 4 cycles -> exactly one wr pulse one cycle later; ram_cs=0x0020, Data=0xDEADBEEF during the pulse, Data=0 afterwards.
- Read, RD_LAT=2: RAM3 slice=0x12345678; Read_in rises at edge k with sel=3 -> busy high for 2 cycles; at edge k+2 Data_rd=0x12345678 and rd_valid pulses once.
- Simultaneous rising Write_in and Read_in, sel=1 -> one wr pulse, no busy, one collision pulse.
- Write_in edge during RD_WAIT -> no wr, one collision pulse, read completes with correct data.
- N_RAM=12, sel=13 write -> sel_err pulse, no wr, ram_cs unchanged. Separately, reset at cycle k+1 of a read -> busy=0, and no rd_valid follows.
